// File: rtl/cpu_ram_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ram_stream_pkg : burst-engine states and lane helpers                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_ram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic ext_width_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    // Lane index of a unit address; ratio is always a power of two.
    function automatic logic [1:0] lane_sel(input logic [31:0] unit, input int ratio);
        return 2'(unit & 32'(ratio - 1));
    endfunction

    function automatic logic [3:0] lane_bytes(input logic [1:0] lane, input int ext_width);
        logic [3:0] base;
        base = 4'((1 << (ext_width / 8)) - 1);
        return 4'(base << (lane * (ext_width / 8)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ram_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ram_stream_if : CPU bus and external burst/stream signal bundle      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cpu_ram_stream_if #(
    parameter int DEPTH     = 4096,
    parameter int EXT_WIDTH = 16
);
    localparam int RATIO = 32 / EXT_WIDTH;
    localparam int EA    = $clog2(DEPTH * RATIO);

    logic                 request;
    logic [31:0]          address;
    logic [3:0]           wmask;
    logic [31:0]          wdata;
    logic                 ack;
    logic [31:0]          rdata;

    logic                 ext_start;
    logic                 ext_write;
    logic [EA-1:0]        ext_address;
    logic [15:0]          ext_length;
    logic                 ext_busy;
    logic                 ext_done;
    logic [EXT_WIDTH-1:0] ext_wdata;
    logic                 ext_wvalid;
    logic                 ext_wready;
    logic [EXT_WIDTH-1:0] ext_rdata;
    logic                 ext_rvalid;
    logic                 ext_rready;

    modport slave (
        input  request, address, wmask, wdata,
        input  ext_start, ext_write, ext_address, ext_length,
        input  ext_wdata, ext_wvalid, ext_rready,
        output ack, rdata, ext_busy, ext_done, ext_wready, ext_rdata, ext_rvalid
    );

    modport master (
        output request, address, wmask, wdata,
        output ext_start, ext_write, ext_address, ext_length,
        output ext_wdata, ext_wvalid, ext_rready,
        input  ack, rdata, ext_busy, ext_done, ext_wready, ext_rdata, ext_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/cpu_ram_stream_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ram_stream_skid : 2-entry valid/ready buffer, bypass when empty      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_ram_stream_skid #(
    parameter int WIDTH = 16
) (
    input  wire              clk_i,
    input  wire              rst_i,
    input  wire              in_valid_i,
    input  wire  [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  wire              out_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    // Producer never offers data it could overflow, so there is no in_ready.
    assign w_empty  = (count_q == 2'd0);
    assign w_bypass = w_empty && in_valid_i && out_ready_i;
    assign w_push   = in_valid_i && !w_bypass;
    assign w_pop    = !w_empty && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                slot_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign out_valid_o = !w_empty || in_valid_i;
    assign out_data_o  = w_empty ? in_data_i : slot_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_ram_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ram_stream : dual-port CPU RAM with a streaming burst external port  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_ram_stream #(
    parameter int DEPTH     = 4096,
    parameter int EXT_WIDTH = 16
) (
    input  wire             clk_i,
    input  wire             rst_i,
    cpu_ram_stream_if.slave bus
);
    import cpu_ram_stream_pkg::*;

    localparam int RATIO = 32 / EXT_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int EA    = $clog2(DEPTH * RATIO);
    localparam int LB    = $clog2(RATIO);

    if (!ext_width_legal(EXT_WIDTH)) begin : g_bad_ext_width
        $error("cpu_ram_stream: EXT_WIDTH must be 8, 16 or 32");
    end

    logic [31:0]          ram_q [DEPTH];
    logic [31:0]          cpu_rd_q;
    logic [EXT_WIDTH-1:0] ext_rd_q;
    logic                 ack_q;

    state_e               state_q;
    logic [EA-1:0]        addr_q;
    logic [15:0]          issue_q;
    logic [15:0]          left_q;
    logic                 in_flight_q;
    logic                 busy_q;
    logic                 done_q;

    logic [AW-1:0]        w_cpu_word;
    logic [AW-1:0]        w_ext_word;
    logic [1:0]           w_lane;
    logic [4:0]           w_shift;
    logic                 w_cpu_wr;
    logic                 w_collide;
    logic                 w_wready;
    logic                 w_whs;
    logic                 w_ext_rd;
    logic                 w_rhs;
    logic [3:0]           w_ext_be;
    logic [31:0]          w_ext_wword;
    logic                 w_skid_valid;
    logic [EXT_WIDTH-1:0] w_skid_data;
    logic [1:0]           w_skid_count;
    logic                 w_unused;

    assign w_unused    = ^{bus.address[31:AW+2], bus.address[1:0]};
    assign w_cpu_word  = bus.address[AW+1:2];
    assign w_ext_word  = addr_q[EA-1:LB];
    assign w_lane      = lane_sel(32'(addr_q), RATIO);
    assign w_shift     = 5'(32'(w_lane) * EXT_WIDTH);
    assign w_cpu_wr    = bus.request && (bus.wmask != 4'b0000);
    // CPU always wins a same-word collision; the external side just waits.
    assign w_collide   = w_cpu_wr && (w_cpu_word == w_ext_word);
    assign w_wready    = (state_q == ST_WRITE) && (left_q != 16'd0) && !w_collide;
    assign w_whs       = w_wready && bus.ext_wvalid;
    assign w_ext_rd    = (state_q == ST_READ) && (issue_q != 16'd0) && !w_collide &&
                         (({1'b0, w_skid_count} + {2'b00, in_flight_q}) < 3'd2);
    assign w_rhs       = w_skid_valid && bus.ext_rready;
    assign w_ext_be    = w_whs ? lane_bytes(w_lane, EXT_WIDTH) : 4'b0000;
    assign w_ext_wword = {RATIO{bus.ext_wdata}};

    always_ff @(posedge clk_i) begin
        if (bus.request) begin
            cpu_rd_q <= ram_q[w_cpu_word];
        end
        if (w_ext_rd) begin
            ext_rd_q <= EXT_WIDTH'(ram_q[w_ext_word] >> w_shift);
        end
        for (int b = 0; b < 4; b++) begin
            if (w_cpu_wr && bus.wmask[b]) begin
                ram_q[w_cpu_word][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
            if (w_ext_be[b]) begin
                ram_q[w_ext_word][8*b +: 8] <= w_ext_wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= bus.request;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_q     <= 16'd0;
            left_q      <= 16'd0;
            in_flight_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_flight_q <= w_ext_rd;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ext_start) begin
                        addr_q  <= bus.ext_address;
                        issue_q <= bus.ext_length;
                        left_q  <= bus.ext_length;
                        busy_q  <= 1'b1;
                        if (bus.ext_length == 16'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= bus.ext_write ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_whs) begin
                        addr_q <= addr_q + 1'b1;
                        left_q <= left_q - 16'd1;
                        if (left_q == 16'd1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_ext_rd) begin
                        addr_q  <= addr_q + 1'b1;
                        issue_q <= issue_q - 16'd1;
                    end
                    if (w_rhs) begin
                        left_q <= left_q - 16'd1;
                        if (left_q == 16'd1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    cpu_ram_stream_skid #(
        .WIDTH (EXT_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_flight_q),
        .in_data_i   (ext_rd_q),
        .out_valid_o (w_skid_valid),
        .out_data_o  (w_skid_data),
        .out_ready_i (bus.ext_rready),
        .count_o     (w_skid_count)
    );

    assign bus.ack        = ack_q;
    assign bus.rdata      = ack_q ? cpu_rd_q : 32'd0;
    assign bus.ext_busy   = busy_q;
    assign bus.ext_done   = done_q;
    assign bus.ext_wready = w_wready;
    assign bus.ext_rvalid = w_skid_valid;
    assign bus.ext_rdata  = w_skid_valid ? w_skid_data : '0;

endmodule
`default_nettype wire

// File: doc/cpu_ram_stream.md
# cpu_ram_stream

Parametrised dual-port CPU RAM with a streaming external port. The CPU side is a single-cycle 32-bit byte-masked bus slave. The external side replaces single-word access with a burst engine: one start command, an auto-incrementing address, and valid/ready streaming of EXT_WIDTH-wide units in either direction. The block sits between the CPU bus decoder and the data-movement logic (USB/flash/DMA), which fills or drains firmware buffers without CPU involvement.

## Interface
Parameters:
- DEPTH, 4096: 32-bit words; power of two, minimum 256.
- EXT_WIDTH, 16: external unit width; legal values 8, 16 or 32.
- Derived: RATIO = 32/EXT_WIDTH; EA = log2(DEPTH*RATIO).

Ports:
- sys.clk  input  1  system clock (if_system.sys); the only clock.
- sys.reset  input  1  asynchronous, active-high reset.
- bus.request  input  1  CPU access strobe.
- bus.address  input  32  byte address; bits [log2(DEPTH)+1:2] are used.
- bus.wmask  input  4  byte write enables; 0 means read.
- bus.wdata  input  32  CPU write data.
- bus.ack  output  1  access acknowledge.
- bus.rdata  output  32  read data; zero when ack is low.
- ext_start  input  1  burst command strobe.
- ext_write  input  1  burst direction, sampled with start; 1 means external to RAM.
- ext_address  input  EA  first unit address, sampled with start.
- ext_length  input  16  unit count, sampled with start.
- ext_busy  output  1  burst in progress.
- ext_done  output  1  one-cycle completion pulse.
- ext_wdata  input  EXT_WIDTH  write stream data.
- ext_wvalid  input  1  write stream valid.
- ext_wready  output  1  write stream ready.
- ext_rdata  output  EXT_WIDTH  read stream data.
- ext_rvalid  output  1  read stream valid.
- ext_rready  input  1  read stream ready.

## Operation
- Storage and lane order:
  - DEPTH x 4 bytes.
  - Unit u maps to word u/RATIO and lane u%RATIO.
  - Lane k occupies bytes [k*EXT_WIDTH/8 +: EXT_WIDTH/8], little-endian.
- CPU port:
  - Every request is acked on the next cycle.
  - Writes update the enabled bytes at the request edge.
  - Read data is the word contents before any same-cycle write.
- State machine:
  - IDLE to WRITE or READ on ext_start. Address, direction and length are latched.
  - IDLE to DONE when ext_length = 0; no transfer occurs.
  - WRITE to DONE after the last wvalid&&wready.
  - READ to DONE after the last rvalid&&rready.
  - DONE to IDLE unconditionally; ext_done = 1 in DONE.
- ext_start outside IDLE is ignored.
- ext_busy = 1 in WRITE, READ and DONE.
- Address increments by 1 per unit, modulo DEPTH*RATIO, so bursts wrap from the top unit to 0.
- WRITE: ext_wready = 1 in WRITE unless a remaining unit count of 0 is reached, or a CPU write (bus.request, wmask != 0) targets the same word this cycle. The CPU always wins the collision.
- READ:
  - A RAM read is issued when output-buffer occupancy plus in-flight reads is below 2, units remain unissued, and no CPU write targets the same word this cycle.
  - Results enter a 2-entry skid buffer that drives ext_rdata and ext_rvalid.
- Reset at any time:
  - State returns to IDLE; skid buffer and in-flight reads are discarded; counters clear.
  - RAM contents are not cleared.

## Timing
- Reset values: bus.ack 0, bus.rdata 0, ext_busy 0, ext_done 0, ext_wready 0, ext_rvalid 0, ext_rdata 0.
- CPU latency: request at cycle N, then ack and rdata at N+1. Back-to-back requests give back-to-back acks.
- Start accepted at edge N: ext_busy = 1 from N+1.
- WRITE:
  - ext_wready can be 1 from N+1.
  - Each accepted unit is visible to a CPU read requested on the following cycle.
- READ:
  - First ext_rvalid at N+2.
  - Sustains one unit per cycle while ext_rready stays 1.
  - ext_rdata is held stable while rvalid=1 and rready=0.
- Completion: ext_done pulses for exactly one cycle after the last handshake; ext_busy falls on the cycle after the done pulse.
- Length 0: done at N+1, busy for that one cycle only.

## Structure
- Package cpu_ram_stream_pkg holds:
  - the state enum (IDLE, WRITE, READ, DONE);
  - a lane-select function;
  - a compile-time check that EXT_WIDTH is in {8,16,32}.
- Sub-module cpu_ram_stream_skid: 2-entry valid/ready output buffer with an occupancy output, used by the READ path.
- RAM is inferred as a true dual-port array with per-byte write enables.

## Test plan
- CPU write 0xDEADBEEF to word 5 with wmask 4'b0101, then read word 5 → ack one cycle after each request; rdata = 0x00AD00EF over a zero-initialised word; rdata = 0 whenever ack is low.
- EXT_WIDTH=16, WRITE burst at address 10, length 4, units 0x1111..0x4444 → CPU reads word 5 = 0x22221111 and word 6 = 0x44443333; ext_done is one pulse.
- READ burst at address DEPTH*2-2, length 4, with rready held high → units come from the top of RAM and then wrap to units 0 and 1, one per cycle starting at N+2.
- READ burst length 6 with rready toggling 1,0,0,1 → no unit lost or duplicated; rdata stable while stalled.
- WRITE burst while the CPU writes the same word in the same cycle → wready = 0 that cycle; the CPU byte lands first; the ext unit is written one cycle later and overwrites only its own lane.
- sys.reset asserted mid-READ with 2 units buffered → rvalid, busy and done drop immediately; a new burst after reset streams correct data.
